// File: rtl/vector_pkg.sv
// Shared types and sizing for the vector combination/unpack path.
package vector_pkg;

    localparam int VEC_WIDTH   = 41;
    localparam int VEC_NIB     = 4;
    localparam int VEC_NGROUPS = 9;
    localparam int VEC_TAG_W   = VEC_WIDTH - VEC_NIB * VEC_NGROUPS;

    typedef logic [VEC_WIDTH-1:0] vec_word_t;
    typedef logic [VEC_NIB-1:0]   vec_nib_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } unpack_state_e;

endpackage

// File: rtl/vector_nib_select.sv
// Combinational group mux: picks the idx-th nibble of the held word,
// optionally inverting it to restore upstream polarity.
module vector_nib_select #(
    parameter int NIB     = 4,
    parameter int NGROUPS = 9,
    parameter int INVERT  = 1,
    parameter int IDX_W   = $clog2(NGROUPS)
) (
    input  logic [NIB*NGROUPS-1:0] data,
    input  logic [IDX_W-1:0]       idx,
    output logic [NIB-1:0]         nib
);

    logic [NIB-1:0] raw;

    always_comb begin
        raw = '0;
        for (int g = 0; g < NGROUPS; g++) begin
            if (idx == IDX_W'(g)) begin
                raw = data[g*NIB +: NIB];
            end
        end
    end

    assign nib = (INVERT != 0) ? ~raw : raw;

endmodule

// File: rtl/vector_unpacker.sv
// Re-serialises a combined vector word into nibble groups, LSB first.
// Optional even-parity sideband enabled by VECTOR_UNPACKER_PARITY_EN.
module vector_unpacker
    import vector_pkg::*;
#(
    parameter int WIDTH   = VEC_WIDTH,
    parameter int NIB     = VEC_NIB,
    parameter int NGROUPS = VEC_NGROUPS,
    parameter int INVERT  = 1,
    parameter int IDX_W   = $clog2(NGROUPS),
    parameter int TAG_W   = WIDTH - NIB * NGROUPS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NIB-1:0]   out_nib,
    output logic [IDX_W-1:0] out_idx,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_last,
`ifdef VECTOR_UNPACKER_PARITY_EN
    output logic             out_par,
`endif
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NGROUPS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    unpack_state_e    state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] hold;
    logic [NIB-1:0]   sel_nib;
    logic             at_last;
    logic             fire;

    assign at_last = (state == SEND) && (idx == LAST_IDX);
    assign fire    = (state == SEND) && out_ready;

    // Only the final nibble's handshake may open the input, enabling
    // back-to-back words without a bubble.
    assign in_ready = (state == IDLE) || (at_last && out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        hold  <= in_data;
                        idx   <= '0;
                        state <= SEND;
                    end
                end
                SEND: begin
                    if (fire) begin
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (in_valid) begin
                                hold <= in_data;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + IDX_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

    vector_nib_select #(
        .NIB     (NIB),
        .NGROUPS (NGROUPS),
        .INVERT  (INVERT),
        .IDX_W   (IDX_W)
    ) u_sel (
        .data (hold[NIB*NGROUPS-1:0]),
        .idx  (idx),
        .nib  (sel_nib)
    );

    assign busy      = (state == SEND);
    assign out_valid = busy;
    assign out_nib   = busy ? sel_nib : '0;
    assign out_idx   = idx;
    assign out_tag   = hold[WIDTH-1:NIB*NGROUPS];
    assign out_last  = at_last;

`ifdef VECTOR_UNPACKER_PARITY_EN
    assign out_par = ^out_nib;
`endif

endmodule

// File: tb/tb_vector_unpacker.sv
// Directed bench for vector_unpacker: plain and inverted instances in parallel.
module tb_vector_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [40:0] in_data;
    logic        out_ready;

    logic        rdy0, vld0, last0, busy0;
    logic [3:0]  nib0, idx0;
    logic [4:0]  tag0;
    logic        rdy1, vld1, last1, busy1;
    logic [3:0]  nib1, idx1;
    logic [4:0]  tag1;
    logic        par0, par1;

    int total = 0;
    int bad   = 0;

    logic [3:0] exp_plain [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                  4'h6, 4'h7, 4'h8, 4'hF};
    logic [3:0] exp_inv   [9] = '{4'hE, 4'hD, 4'hC, 4'hB, 4'hA,
                                  4'h9, 4'h8, 4'h7, 4'h0};
    logic       exp_par   [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b1, 1'b1, 1'b0};

    localparam logic [40:0] WORD_A = 41'h01F87654321;
    localparam logic [40:0] WORD_B = 41'h1FFFFFFFFFF;

    vector_unpacker #(.INVERT(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy0),
        .in_data   (in_data),
        .out_valid (vld0),
        .out_ready (out_ready),
        .out_nib   (nib0),
        .out_idx   (idx0),
        .out_tag   (tag0),
        .out_last  (last0),
`ifdef VECTOR_UNPACKER_PARITY_EN
        .out_par   (par0),
`endif
        .busy      (busy0)
    );

    vector_unpacker #(.INVERT(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy1),
        .in_data   (in_data),
        .out_valid (vld1),
        .out_ready (out_ready),
        .out_nib   (nib1),
        .out_idx   (idx1),
        .out_tag   (tag1),
        .out_last  (last1),
`ifdef VECTOR_UNPACKER_PARITY_EN
        .out_par   (par1),
`endif
        .busy      (busy1)
    );

`ifndef VECTOR_UNPACKER_PARITY_EN
    assign par0 = 1'b0;
    assign par1 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " in_ready0"}, 64'(rdy0), 64'd1);
        chk({tag, " valid0"}, 64'(vld0), 64'd0);
        chk({tag, " nib0"}, 64'(nib0), 64'd0);
        chk({tag, " idx0"}, 64'(idx0), 64'd0);
        chk({tag, " tag0"}, 64'(tag0), 64'd0);
        chk({tag, " last0"}, 64'(last0), 64'd0);
        chk({tag, " busy0"}, 64'(busy0), 64'd0);
        chk({tag, " par0"}, 64'(par0), 64'd0);
        chk({tag, " in_ready1"}, 64'(rdy1), 64'd1);
        chk({tag, " valid1"}, 64'(vld1), 64'd0);
        chk({tag, " nib1"}, 64'(nib1), 64'd0);
        chk({tag, " tag1"}, 64'(tag1), 64'd0);
        chk({tag, " par1"}, 64'(par1), 64'd0);
    endtask

    task automatic chk_nib(input string tag, input int i,
                           input logic [4:0] etag, input logic ein_rdy);
        chk({tag, " valid"}, 64'(vld0), 64'd1);
        chk({tag, " idx"}, 64'(idx0), 64'(i));
        chk({tag, " idx inv"}, 64'(idx1), 64'(i));
        chk({tag, " nib"}, 64'(nib0), 64'(exp_plain[i]));
        chk({tag, " nib inv"}, 64'(nib1), 64'(exp_inv[i]));
        chk({tag, " tag"}, 64'(tag0), 64'(etag));
        chk({tag, " tag inv"}, 64'(tag1), 64'(etag));
        chk({tag, " last"}, 64'(last0), 64'(i == 8));
        chk({tag, " in_ready"}, 64'(rdy0), 64'(ein_rdy));
        chk({tag, " busy"}, 64'(busy0), 64'd1);
`ifdef VECTOR_UNPACKER_PARITY_EN
        chk({tag, " par"}, 64'(par0), 64'(exp_par[i]));
        chk({tag, " par inv"}, 64'(par1), 64'(exp_par[i]));
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #2;
        chk_reset("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
        chk_reset("idle after release");

        // single word, continuous out_ready
        in_data  = WORD_A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            chk_nib($sformatf("w1 i%0d", i), i, 5'h01, i == 8);
            step();
        end
        chk("w1 done valid", 64'(vld0), 64'd0);
        chk("w1 done busy", 64'(busy1), 64'd0);
        chk("w1 done in_ready", 64'(rdy0), 64'd1);
        chk("w1 done nib", 64'(nib1), 64'd0);

        // back-to-back: second word waits with in_valid high
        in_data  = WORD_A;
        in_valid = 1'b1;
        step();
        in_data = WORD_B;
        for (int i = 0; i < 9; i++) begin
            chk_nib($sformatf("b2b i%0d", i), i, 5'h01, i == 8);
            step();
        end
        in_valid = 1'b0;
        chk("b2b w2 valid", 64'(vld0), 64'd1);
        chk("b2b w2 idx", 64'(idx0), 64'd0);
        chk("b2b w2 nib", 64'(nib0), 64'hF);
        chk("b2b w2 nib inv", 64'(nib1), 64'h0);
        chk("b2b w2 tag", 64'(tag0), 64'h1F);
        chk("b2b w2 in_ready", 64'(rdy0), 64'd0);
        for (int i = 0; i < 9; i++) step();
        chk("b2b w2 done valid", 64'(vld0), 64'd0);

        // backpressure at idx 4
        in_data  = WORD_A;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_nib($sformatf("bp c%0d", c), 4, 5'h01, 1'b0);
            step();
        end
        chk_nib("bp end", 4, 5'h01, 1'b0);
        out_ready = 1'b1;
        step();
        chk_nib("bp resume", 5, 5'h01, 1'b0);

        // asynchronous reset mid-word at idx 5
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid reset");
        step();
        rst_n = 1'b1;
        step();
        chk_reset("post reset");
        step();
        chk("post reset valid", 64'(vld1), 64'd0);
        chk("post reset idx", 64'(idx1), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
